// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller.
package csr_pkg;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  // CSR indices
  localparam logic [11:0] CsrMstatus       = 12'h300;
  localparam logic [11:0] CsrMisa          = 12'h301;
  localparam logic [11:0] CsrMie           = 12'h304;
  localparam logic [11:0] CsrMtvec         = 12'h305;
  localparam logic [11:0] CsrMcountinhibit = 12'h320;
  localparam logic [11:0] CsrMscratch      = 12'h340;
  localparam logic [11:0] CsrMepc          = 12'h341;
  localparam logic [11:0] CsrMcause        = 12'h342;
  localparam logic [11:0] CsrMtval         = 12'h343;
  localparam logic [11:0] CsrMip           = 12'h344;
  localparam logic [11:0] CsrMcycle        = 12'hB00;
  localparam logic [11:0] CsrMinstret      = 12'hB02;
  localparam logic [11:0] CsrMcycleh       = 12'hB80;
  localparam logic [11:0] CsrMinstreth     = 12'hB82;
  localparam logic [11:0] CsrMvendorid     = 12'hF11;
  localparam logic [11:0] CsrMarchid       = 12'hF12;
  localparam logic [11:0] CsrMimpid        = 12'hF13;
  localparam logic [11:0] CsrMhartid       = 12'hF14;

  // Exception and interrupt cause codes
  localparam logic [3:0] ExcIllegal = 4'd2;
  localparam logic [3:0] ExcBreak   = 4'd3;
  localparam logic [3:0] ExcEcall   = 4'd11;
  localparam logic [3:0] IntMsi     = 4'd3;
  localparam logic [3:0] IntMti     = 4'd7;
  localparam logic [3:0] IntMei     = 4'd11;

  // mstatus / mie / mip bit positions
  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned IrqMsiBit   = 3;
  localparam int unsigned IrqMtiBit   = 7;
  localparam int unsigned IrqMeiBit   = 11;

  // Writable-bit masks and hardwired fields
  localparam logic [7:0]  MstatusWmask       = 8'h88;
  localparam logic [63:0] MstatusMpp         = 64'h1800;
  localparam logic [11:0] MieWmask           = 12'h888;
  localparam logic [2:0]  McountinhibitWmask = 3'b101;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and split lo/hi CSR write ports.
module csr_counter64 #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            inhibit,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     value
);

  logic [63:0] cnt_q, cnt_d;

  // Explicit writes win over the increment; the unwritten half holds.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[XLEN-1:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[63:32] = wdata[31:0];
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, exception/interrupt trap controller and mret handling.
module csr_trap_unit import csr_pkg::*; #(
  parameter int unsigned XLEN        = 64,
  parameter logic [63:0] HARTID      = 64'd0,
  parameter logic [63:0] MTVEC_RESET = 64'd0,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [11:0]     csr_index,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            inst_ecall,
  input  logic            inst_ebreak,
  input  logic            inst_mret,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            retire
);

  localparam logic [XLEN-1:0] Misa =
      {(XLEN == 32) ? 2'b01 : 2'b10, {(XLEN-11){1'b0}}, 9'h100};

  logic [7:0]      mstatus_q, mstatus_d;
  logic [11:0]     mie_q, mie_d, mip_q;
  logic [2:0]      mcountinhibit_q, mcountinhibit_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d, mscratch_q, mscratch_d;
  logic [63:0]     mcycle_val, minstret_val;

  logic            valid, known, read_only, wr_attempt, csr_we;
  logic [XLEN-1:0] wval, mepc_rd, tvec_base;
  logic [11:0]     pending;
  logic            trap, is_irq, is_ebreak, mret_take;
  logic [3:0]      cause;

  assign valid   = inst_valid & ~rst;
  assign mepc_rd = mepc_q & ~XLEN'(1);

  // CSR read mux and address decode
  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_index)
      CsrMstatus:       csr_rdata = XLEN'(MstatusMpp) | XLEN'(mstatus_q);
      CsrMisa:          begin csr_rdata = Misa; read_only = 1'b1; end
      CsrMie:           csr_rdata = XLEN'(mie_q);
      CsrMtvec:         csr_rdata = mtvec_q;
      CsrMcountinhibit: csr_rdata = XLEN'(mcountinhibit_q);
      CsrMscratch:      csr_rdata = mscratch_q;
      CsrMepc:          csr_rdata = mepc_rd;
      CsrMcause:        csr_rdata = mcause_q;
      CsrMtval:         csr_rdata = mtval_q;
      CsrMip:           begin csr_rdata = XLEN'(mip_q); read_only = 1'b1; end
      CsrMcycle:        csr_rdata = mcycle_val[XLEN-1:0];
      CsrMinstret:      csr_rdata = minstret_val[XLEN-1:0];
      CsrMcycleh: begin
        if (XLEN == 32) csr_rdata = XLEN'(mcycle_val[63:32]);
        else            known = 1'b0;
      end
      CsrMinstreth: begin
        if (XLEN == 32) csr_rdata = XLEN'(minstret_val[63:32]);
        else            known = 1'b0;
      end
      CsrMvendorid:     read_only = 1'b1;
      CsrMarchid:       begin csr_rdata = XLEN'(1); read_only = 1'b1; end
      CsrMimpid:        read_only = 1'b1;
      CsrMhartid:       begin csr_rdata = XLEN'(HARTID); read_only = 1'b1; end
      default:          known = 1'b0;
    endcase
  end

  // Read-modify-write operand and legality; rs/rc with zero operand is a pure read
  always_comb begin
    wval = csr_wdata;
    unique case (csr_op)
      CsrOpRs: wval = csr_rdata | csr_wdata;
      CsrOpRc: wval = csr_rdata & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
    wr_attempt  = (csr_op == CsrOpRw) || ((csr_op != CsrOpNone) && (|csr_wdata));
    csr_illegal = (csr_op != CsrOpNone) && (!known || (read_only && wr_attempt));
  end

  // Trap arbitration: interrupts first, then synchronous exceptions
  always_comb begin
    pending   = mip_q & mie_q & {12{mstatus_q[MstatusMie]}};
    trap      = 1'b0;
    is_irq    = 1'b0;
    is_ebreak = 1'b0;
    cause     = 4'd0;
    if (valid) begin
      trap = 1'b1;
      if (pending[IrqMeiBit])      begin is_irq = 1'b1; cause = IntMei; end
      else if (pending[IrqMsiBit]) begin is_irq = 1'b1; cause = IntMsi; end
      else if (pending[IrqMtiBit]) begin is_irq = 1'b1; cause = IntMti; end
      else if (csr_illegal)        cause = ExcIllegal;
      else if (inst_ecall)         cause = ExcEcall;
      else if (inst_ebreak)        begin cause = ExcBreak; is_ebreak = 1'b1; end
      else                         trap = 1'b0;
    end
    mret_take = valid & inst_mret & ~trap;
    retire    = valid & ~trap;
    csr_we    = valid & wr_attempt & ~csr_illegal & ~trap;
  end

  // Redirect target: mtvec base (plus 4*cause for vectored interrupts) or mepc
  always_comb begin
    tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    redirect    = trap | mret_take;
    redirect_pc = '0;
    if (trap) begin
      redirect_pc = (is_irq && mtvec_q[1:0] == 2'b01) ? tvec_base + XLEN'({cause, 2'b00})
                                                      : tvec_base;
    end else if (mret_take) begin
      redirect_pc = mepc_rd;
    end
  end

  // CSR next state: explicit writes, then trap entry or mret
  always_comb begin
    mstatus_d       = mstatus_q;
    mie_d           = mie_q;
    mcountinhibit_d = mcountinhibit_q;
    mtvec_d         = mtvec_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mscratch_d      = mscratch_q;
    if (csr_we) begin
      case (csr_index)
        CsrMstatus:       mstatus_d = wval[7:0] & MstatusWmask;
        CsrMie:           mie_d = wval[11:0] & MieWmask;
        CsrMcountinhibit: mcountinhibit_d = wval[2:0] & McountinhibitWmask;
        CsrMtvec: begin
          mtvec_d = {wval[XLEN-1:2], mtvec_q[1:0]};
          if (wval[1:0] == 2'b00)      mtvec_d[1:0] = 2'b00;
          else if (wval[1:0] == 2'b01) mtvec_d[1:0] = VECTORED_EN ? 2'b01 : 2'b00;
        end
        CsrMepc:          mepc_d = wval;
        CsrMcause:        mcause_d = wval;
        CsrMtval:         mtval_d = wval;
        CsrMscratch:      mscratch_d = wval;
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d                 = inst_addr;
      mcause_d               = {is_irq, (XLEN-1)'(cause)};
      mtval_d                = is_ebreak ? inst_addr : '0;
      mstatus_d[MstatusMpie] = mstatus_q[MstatusMie];
      mstatus_d[MstatusMie]  = 1'b0;
    end else if (mret_take) begin
      mstatus_d[MstatusMie]  = mstatus_q[MstatusMpie];
      mstatus_d[MstatusMpie] = 1'b1;
    end
  end

  // CSR state registers; mip samples the interrupt levels once
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q       <= '0;
      mie_q           <= '0;
      mip_q           <= '0;
      mcountinhibit_q <= '0;
      mtvec_q         <= MTVEC_RESET[XLEN-1:0];
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      mscratch_q      <= '0;
    end else begin
      mstatus_q       <= mstatus_d;
      mie_q           <= mie_d;
      mip_q           <= {irq_meip, 3'b000, irq_mtip, 3'b000, irq_msip, 3'b000};
      mcountinhibit_q <= mcountinhibit_d;
      mtvec_q         <= mtvec_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mscratch_q      <= mscratch_d;
    end
  end

  csr_counter64 #(
    .XLEN (XLEN)
  ) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .inhibit (mcountinhibit_q[0]),
    .wr_lo   (csr_we && csr_index == CsrMcycle),
    .wr_hi   (csr_we && csr_index == CsrMcycleh),
    .wdata   (wval),
    .value   (mcycle_val)
  );

  csr_counter64 #(
    .XLEN (XLEN)
  ) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire),
    .inhibit (mcountinhibit_q[2]),
    .wr_lo   (csr_we && csr_index == CsrMinstret),
    .wr_hi   (csr_we && csr_index == CsrMinstreth),
    .wdata   (wval),
    .value   (minstret_val)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench: a 64-bit instance for CSR/trap behaviour and a 32-bit one for split counters.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 64-bit instance signals
  logic        a_valid, a_ecall, a_ebreak, a_mret, a_mtip, a_msip, a_meip;
  logic [63:0] a_addr, a_wdata, a_rdata, a_rpc;
  logic [11:0] a_idx;
  logic [1:0]  a_op;
  logic        a_ill, a_redir, a_retire;

  // 32-bit instance signals
  logic        b_valid;
  logic [31:0] b_addr, b_wdata, b_rdata, b_rpc;
  logic [11:0] b_idx;
  logic [1:0]  b_op;
  logic        b_ill, b_redir, b_retire;

  csr_trap_unit #(
    .XLEN        (64),
    .HARTID      (64'd5),
    .MTVEC_RESET (64'h1000),
    .VECTORED_EN (1'b1)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (a_valid),
    .inst_addr   (a_addr),
    .csr_index   (a_idx),
    .csr_op      (a_op),
    .csr_wdata   (a_wdata),
    .inst_ecall  (a_ecall),
    .inst_ebreak (a_ebreak),
    .inst_mret   (a_mret),
    .irq_mtip    (a_mtip),
    .irq_msip    (a_msip),
    .irq_meip    (a_meip),
    .csr_rdata   (a_rdata),
    .csr_illegal (a_ill),
    .redirect    (a_redir),
    .redirect_pc (a_rpc),
    .retire      (a_retire)
  );

  csr_trap_unit #(
    .XLEN        (32),
    .HARTID      (64'd9),
    .MTVEC_RESET (64'h0),
    .VECTORED_EN (1'b0)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (b_valid),
    .inst_addr   (b_addr),
    .csr_index   (b_idx),
    .csr_op      (b_op),
    .csr_wdata   (b_wdata),
    .inst_ecall  (1'b0),
    .inst_ebreak (1'b0),
    .inst_mret   (1'b0),
    .irq_mtip    (1'b0),
    .irq_msip    (1'b0),
    .irq_meip    (1'b0),
    .csr_rdata   (b_rdata),
    .csr_illegal (b_ill),
    .redirect    (b_redir),
    .redirect_pc (b_rpc),
    .retire      (b_retire)
  );

  typedef struct {
    logic [11:0] idx;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic        ill;
    logic [63:0] rb;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_valid = 1'b0; a_addr = '0; a_idx = '0; a_op = 2'b00; a_wdata = '0;
    a_ecall = 1'b0; a_ebreak = 1'b0; a_mret = 1'b0;
  endtask

  task automatic b_idle();
    b_valid = 1'b0; b_addr = '0; b_idx = '0; b_op = 2'b00; b_wdata = '0;
  endtask

  task automatic a_chk_csr(input string name, input logic [11:0] idx, input logic [63:0] exp);
    a_valid = 1'b0; a_op = 2'b00; a_idx = idx;
    #1;
    chk(name, a_rdata, exp);
  endtask

  task automatic b_chk_csr(input string name, input logic [11:0] idx, input logic [63:0] exp);
    b_valid = 1'b0; b_op = 2'b00; b_idx = idx;
    #1;
    chk(name, {32'd0, b_rdata}, exp);
  endtask

  task automatic a_csr(input logic [11:0] idx, input logic [1:0] op, input logic [63:0] wd);
    a_valid = 1'b1; a_addr = 64'h1000_0000; a_idx = idx; a_op = op; a_wdata = wd;
    step();
    a_idle();
  endtask

  task automatic b_csr(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] wd);
    b_valid = 1'b1; b_addr = 32'h2000; b_idx = idx; b_op = op; b_wdata = wd;
    step();
    b_idle();
  endtask

  initial begin
    vecs[0]  = '{CsrMscratch, 2'b01, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[1]  = '{CsrMscratch, 2'b10, 64'h0000_0000_0000_00F0, 1'b0, 64'hDEAD_BEEF_0123_45F7};
    vecs[2]  = '{CsrMscratch, 2'b11, 64'hFFFF_0000_0000_0000, 1'b0, 64'h0000_BEEF_0123_45F7};
    vecs[3]  = '{CsrMstatus,  2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1888};
    vecs[4]  = '{CsrMstatus,  2'b11, 64'h88,                  1'b0, 64'h1800};
    vecs[5]  = '{CsrMie,      2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h888};
    vecs[6]  = '{CsrMie,      2'b01, 64'h0,                   1'b0, 64'h0};
    vecs[7]  = '{CsrMtvec,    2'b01, 64'h4003,                1'b0, 64'h4000};
    vecs[8]  = '{CsrMtvec,    2'b01, 64'h5001,                1'b0, 64'h5001};
    vecs[9]  = '{CsrMtvec,    2'b01, 64'h4002,                1'b0, 64'h4001};
    vecs[10] = '{CsrMepc,     2'b01, 64'h203,                 1'b0, 64'h202};
    vecs[11] = '{CsrMcountinhibit, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h5};
    vecs[12] = '{CsrMcountinhibit, 2'b01, 64'h0,              1'b0, 64'h0};
    vecs[13] = '{CsrMhartid,  2'b10, 64'h0,                   1'b0, 64'h5};
    vecs[14] = '{CsrMhartid,  2'b01, 64'h1,                   1'b1, 64'h5};
    vecs[15] = '{CsrMip,      2'b01, 64'h0,                   1'b1, 64'h0};
    vecs[16] = '{12'h7C0,     2'b10, 64'h0,                   1'b1, 64'h0};
    vecs[17] = '{CsrMcycleh,  2'b01, 64'h1,                   1'b1, 64'h0};
    vecs[18] = '{CsrMisa,     2'b10, 64'h0,                   1'b0, 64'h8000_0000_0000_0100};
    vecs[19] = '{CsrMarchid,  2'b10, 64'h0,                   1'b0, 64'h1};
    vecs[20] = '{CsrMtval,    2'b01, 64'hABCD,                1'b0, 64'hABCD};
    vecs[21] = '{CsrMcause,   2'b10, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0002};

    a_idle(); b_idle();
    a_mtip = 1'b0; a_msip = 1'b0; a_meip = 1'b0;

    // Reset state and free-running mcycle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_redirect", {63'd0, a_redir}, 64'd0);
    chk("reset_retire", {63'd0, a_retire}, 64'd0);
    a_chk_csr("reset_mstatus", CsrMstatus, 64'h1800);
    a_chk_csr("reset_mtvec", CsrMtvec, 64'h1000);
    a_chk_csr("reset_mip", CsrMip, 64'h0);
    for (int i = 0; i < 10; i++) step();
    a_chk_csr("mcycle_10", CsrMcycle, 64'd10);
    a_chk_csr("minstret_0", CsrMinstret, 64'd0);

    // Table of single CSR accesses followed by a read-back
    for (int i = 0; i < 22; i++) begin
      a_valid = 1'b1; a_addr = 64'h3000; a_idx = vecs[i].idx; a_op = vecs[i].op;
      a_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_illegal", i), {63'd0, a_ill}, {63'd0, vecs[i].ill});
      chk($sformatf("vec%0d_retire", i), {63'd0, a_retire}, {63'd0, ~vecs[i].ill});
      step();
      a_idle();
      a_chk_csr($sformatf("vec%0d_readback", i), vecs[i].idx, vecs[i].rb);
    end

    // Vectored timer interrupt
    a_csr(CsrMtvec, 2'b01, 64'h8000_0001);
    a_csr(CsrMie, 2'b01, 64'h80);
    a_csr(CsrMstatus, 2'b10, 64'h8);
    a_mtip = 1'b1;
    #1;
    chk("irq_novalid_redirect", {63'd0, a_redir}, 64'd0);
    step();
    a_valid = 1'b1; a_addr = 64'h100;
    #1;
    chk("mti_redirect", {63'd0, a_redir}, 64'd1);
    chk("mti_pc", a_rpc, 64'h8000_001C);
    chk("mti_retire", {63'd0, a_retire}, 64'd0);
    step();
    a_idle();
    a_mtip = 1'b0;
    a_chk_csr("mti_mepc", CsrMepc, 64'h100);
    a_chk_csr("mti_mcause", CsrMcause, 64'h8000_0000_0000_0007);
    a_chk_csr("mti_mstatus", CsrMstatus, 64'h1880);

    // ecall, mret, ebreak
    a_csr(CsrMtvec, 2'b01, 64'h4000);
    a_csr(CsrMstatus, 2'b01, 64'h8);
    a_valid = 1'b1; a_addr = 64'h200; a_ecall = 1'b1;
    #1;
    chk("ecall_redirect", {63'd0, a_redir}, 64'd1);
    chk("ecall_pc", a_rpc, 64'h4000);
    chk("ecall_retire", {63'd0, a_retire}, 64'd0);
    step();
    a_idle();
    a_chk_csr("ecall_mcause", CsrMcause, 64'd11);
    a_chk_csr("ecall_mtval", CsrMtval, 64'd0);
    a_chk_csr("ecall_mepc", CsrMepc, 64'h200);
    a_chk_csr("ecall_mstatus", CsrMstatus, 64'h1880);
    a_valid = 1'b1; a_addr = 64'h4000; a_mret = 1'b1;
    #1;
    chk("mret_redirect", {63'd0, a_redir}, 64'd1);
    chk("mret_pc", a_rpc, 64'h200);
    chk("mret_retire", {63'd0, a_retire}, 64'd1);
    step();
    a_idle();
    a_chk_csr("mret_mstatus", CsrMstatus, 64'h1888);
    a_valid = 1'b1; a_addr = 64'h300; a_ebreak = 1'b1;
    step();
    a_idle();
    a_chk_csr("ebreak_mcause", CsrMcause, 64'd3);
    a_chk_csr("ebreak_mtval", CsrMtval, 64'h300);
    a_chk_csr("ebreak_mstatus", CsrMstatus, 64'h1880);

    // Interrupt priority and global enable
    a_csr(CsrMie, 2'b01, 64'h888);
    a_csr(CsrMstatus, 2'b10, 64'h8);
    a_meip = 1'b1; a_mtip = 1'b1;
    step();
    a_valid = 1'b1; a_addr = 64'h400; a_ecall = 1'b1;
    #1;
    chk("mei_redirect", {63'd0, a_redir}, 64'd1);
    chk("mei_pc_direct", a_rpc, 64'h4000);
    step();
    a_idle();
    a_chk_csr("mei_mcause", CsrMcause, 64'h8000_0000_0000_000B);
    a_valid = 1'b1; a_addr = 64'h404;
    #1;
    chk("mie0_redirect", {63'd0, a_redir}, 64'd0);
    chk("mie0_retire", {63'd0, a_retire}, 64'd1);
    step();
    a_idle();
    a_meip = 1'b0; a_msip = 1'b1;
    a_csr(CsrMstatus, 2'b10, 64'h8);
    a_valid = 1'b1; a_addr = 64'h408;
    #1;
    chk("msi_redirect", {63'd0, a_redir}, 64'd1);
    step();
    a_idle();
    a_chk_csr("msi_mcause", CsrMcause, 64'h8000_0000_0000_0003);
    a_msip = 1'b0; a_mtip = 1'b0;
    step(); step();

    // Illegal CSR write and legal pure read of a read-only CSR
    a_valid = 1'b1; a_addr = 64'h500; a_idx = CsrMhartid; a_op = 2'b01; a_wdata = 64'h77;
    #1;
    chk("ill_flag", {63'd0, a_ill}, 64'd1);
    chk("ill_redirect", {63'd0, a_redir}, 64'd1);
    chk("ill_retire", {63'd0, a_retire}, 64'd0);
    step();
    a_idle();
    a_chk_csr("ill_mcause", CsrMcause, 64'd2);
    a_chk_csr("ill_mepc", CsrMepc, 64'h500);
    a_chk_csr("ill_hartid", CsrMhartid, 64'd5);
    a_valid = 1'b1; a_addr = 64'h504; a_idx = CsrMhartid; a_op = 2'b10; a_wdata = 64'h0;
    #1;
    chk("rs0_flag", {63'd0, a_ill}, 64'd0);
    chk("rs0_rdata", a_rdata, 64'd5);
    chk("rs0_retire", {63'd0, a_retire}, 64'd1);
    step();
    a_idle();

    // No write without inst_valid
    a_idx = CsrMscratch; a_op = 2'b01; a_wdata = 64'h1111;
    #1;
    chk("novalid_retire", {63'd0, a_retire}, 64'd0);
    step();
    a_idle();
    a_chk_csr("novalid_mscratch", CsrMscratch, 64'h0000_BEEF_0123_45F7);

    // 32-bit instance: mtvec legalisation and split counters
    b_csr(CsrMtvec, 2'b01, 32'h4001);
    b_chk_csr("b_mtvec_direct", CsrMtvec, 64'h4000);
    b_chk_csr("b_misa", CsrMisa, 64'h4000_0100);
    b_chk_csr("b_hartid", CsrMhartid, 64'd9);
    b_csr(CsrMcycle, 2'b01, 32'hFFFF_FFFF);
    b_chk_csr("b_mcycleh_written", CsrMcycleh, 64'd0);
    step();
    b_chk_csr("b_mcycleh_carry", CsrMcycleh, 64'd1);
    b_chk_csr("b_mcycle_wrap", CsrMcycle, 64'd0);
    b_csr(CsrMinstret, 2'b01, 32'h55);
    b_chk_csr("b_minstret_wins", CsrMinstret, 64'h55);
    b_chk_csr("b_minstreth_held", CsrMinstreth, 64'd0);
    b_csr(CsrMinstreth, 2'b01, 32'h7);
    b_chk_csr("b_minstreth_wr", CsrMinstreth, 64'd7);
    b_chk_csr("b_minstret_lo_held", CsrMinstret, 64'h55);
    b_csr(CsrMcountinhibit, 2'b01, 32'hF);
    b_chk_csr("b_inhibit", CsrMcountinhibit, 64'h5);
    b_chk_csr("b_minstret_last_inc", CsrMinstret, 64'h56);
    b_csr(CsrMcycle, 2'b01, 32'h1234);
    b_valid = 1'b1; b_addr = 32'h3000;
    #1;
    chk("b_retire", {63'd0, b_retire}, 64'd1);
    step(); step(); step();
    b_idle();
    b_chk_csr("b_mcycle_frozen", CsrMcycle, 64'h1234);
    b_chk_csr("b_mcycleh_frozen", CsrMcycleh, 64'd1);
    b_chk_csr("b_minstret_frozen", CsrMinstret, 64'h56);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
